// File: rtl/mef_controller.sv
// Run controller for the mef sequence detector. It latches an A/B batch and resets the detector.
// It then streams one bit pair per cycle and tallies the Moore Z samples into a count and a first-hit index.
module mef_controller #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  pat_a,
  input  logic [N-1:0]  pat_b,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] z_count,
  output logic [CW-1:0] z_first,
  output logic          det_rst,
  output logic          det_a,
  output logic          det_b,
  input  logic          det_z
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] N_CW     = CW'(N);
  localparam logic [CW-1:0] ALL_ONES = '1;

  state_t        state;
  logic [N-1:0]  pa_q;
  logic [N-1:0]  pb_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] step;
  logic [CW-1:0] len_clamped;
  logic [CW-1:0] bit_idx;
  logic          sample_z;

  assign len_clamped = (len > N_CW) ? N_CW : len;

  // Z seen during step i belongs to bit i-1; step is left at len in DRAIN so the same rule covers the last bit.
  assign bit_idx  = step - CW'(1);
  assign sample_z = det_z && (((state == S_RUN) && (step != '0)) || (state == S_DRAIN));

  assign busy    = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
  assign done    = (state == S_DONE);
  assign det_rst = rst || (state == S_CLEAR);

  // Patterns are consumed LSB first by shifting, so the next bit to drive is always at position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pa_q    <= '0;
      pb_q    <= '0;
      len_q   <= '0;
      step    <= '0;
      z_count <= '0;
      z_first <= ALL_ONES;
      det_a   <= 1'b0;
      det_b   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          det_a <= 1'b0;
          det_b <= 1'b0;
          if (start) begin
            pa_q    <= pat_a;
            pb_q    <= pat_b;
            len_q   <= len_clamped;
            z_count <= '0;
            z_first <= ALL_ONES;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          step <= '0;
          if (len_q != '0) begin
            det_a <= pa_q[0];
            det_b <= pb_q[0];
            pa_q  <= pa_q >> 1;
            pb_q  <= pb_q >> 1;
            state <= S_RUN;
          end else begin
            state <= S_DONE;
          end
        end
        S_RUN: begin
          step <= step + CW'(1);
          if (step == len_q - CW'(1)) begin
            det_a <= 1'b0;
            det_b <= 1'b0;
            state <= S_DRAIN;
          end else begin
            det_a <= pa_q[0];
            det_b <= pb_q[0];
            pa_q  <= pa_q >> 1;
            pb_q  <= pb_q >> 1;
          end
        end
        S_DRAIN: begin
          det_a <= 1'b0;
          det_b <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          det_a <= 1'b0;
          det_b <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (sample_z) begin
        z_count <= z_count + CW'(1);
        if (z_first == ALL_ONES) z_first <= bit_idx;
      end
    end
  end

endmodule

// File: doc/mef_controller.md
# mef_controller

Run controller for the `mef` sequence detector. It captures a batch of A/B stimulus bits and clears the detector. It then drives one bit pair per cycle into the detector, samples the detector's Moore output Z one cycle later, and reports how many bits produced Z=1 and the index of the first such bit. It sits between a host or test sequencer and a single `mef` instance and owns that instance's `rst`, `A` and `B` inputs.

## Interface

Parameters:
- `N`, 16: maximum batch length in bits.
- `CW`, 5: width of the length, count and index fields. Must satisfy 2^CW − 1 > N.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  run request. Sampled only in IDLE.
- `pat_a`  in  N  A bits. Bit i is applied in step i (LSB first).
- `pat_b`  in  N  B bits, same ordering as `pat_a`.
- `len`  in  CW  number of bits to apply, 0..N. Values above N are treated as N.
- `busy`  out  1  high in CLEAR, RUN and DRAIN.
- `done`  out  1  one-cycle pulse in DONE.
- `z_count`  out  CW  number of applied bits whose following Z sample was 1.
- `z_first`  out  CW  index of the first bit giving Z=1. All-ones means no bit gave Z=1.
- `det_rst`  out  1  to `mef.rst`.
- `det_a`  out  1  to `mef.A`.
- `det_b`  out  1  to `mef.B`.
- `det_z`  in  1  from `mef.Z`.

## Operation

- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `pat_a`, `pat_b` and the clamped `len` into internal registers.
  - Same edge: clears `z_count` to 0 and sets `z_first` to all-ones.
  - Next state CLEAR.
- CLEAR (one cycle):
  - `det_rst`=1 and `det_z` is ignored.
  - Next state is RUN if the latched len > 0, otherwise DONE.
- RUN:
  - Step index i runs 0..len−1, one step per cycle.
  - `det_a` = latched A bit i, `det_b` = latched B bit i.
  - At i ≥ 1, `det_z` is the result of bit i−1. At i = 0, `det_z` is ignored (detector is in INIT).
  - After step len−1, next state is DRAIN.
- DRAIN (one cycle): `det_a`=`det_b`=0. `det_z` is sampled as the result of bit len−1. Next state DONE.
- Sampling rule: when a sampled `det_z`=1 for bit k, `z_count` increments. `z_first` takes the value k only if it is still all-ones.
- DONE (one cycle): `done`=1. Next state IDLE.
- Results hold until the next accepted `start`.
- `start` outside IDLE is ignored, including `start` in DONE.
- `det_a`/`det_b` are 0 in every state except RUN.
- `det_rst` = `rst` OR (state == CLEAR).
- Reset at any time:
  - Next state IDLE. Registered `det_a`/`det_b` are 0 from the next cycle.
  - `det_rst`=1 while `rst` is high.
  - An interrupted run produces no `done`.
- Reset values:
  - Outputs: `busy` 0, `done` 0, `z_count` 0, `z_first` all-ones, `det_a` 0, `det_b` 0, `det_rst` 1.
  - Latched pattern and length registers: 0.

## Timing

- Let `start` be accepted at edge k:
  - CLEAR occupies cycle k+1.
  - RUN occupies cycles k+2 .. k+len+1.
  - DRAIN occupies cycle k+len+2.
  - DONE (`done`=1) occupies cycle k+len+3. For len=0, DONE is cycle k+2.
- Final `z_count`/`z_first` are valid in the DONE cycle.
- The next `start` can be accepted in the cycle after DONE. Back-to-back throughput is len+4 cycles per batch.
- `det_a`/`det_b` are registered outputs: the value for step i is stable for the whole of RUN cycle i.
- `busy` and `done` are decoded from the state register and never overlap.

## Test plan

Each scenario runs with `mef` connected.

1. `len`=4, `pat_a`=4'b0000, `pat_b`=0 -> Z after bits = 0,1,1,1. At DONE: `z_count`=3, `z_first`=1. `done` is high exactly 7 cycles after `start` is accepted.
2. `len`=8, `pat_a`=8'h55, `pat_b`=0 -> `z_count`=0, `z_first`=31.
3. `len`=4, `pat_a`=4'b0011, `pat_b`=4'b0100 -> Z = 0,1,1,1. `z_count`=3, `z_first`=1.
4. `len`=16, `pat_a`=16'hFFFF, then `len`=0:
   - First run: `z_count`=15, `z_first`=1.
   - Second run: `done` 2 cycles after accept, `z_count`=0, `z_first`=31, and `det_a` stays 0 throughout.
5. `start` held high continuously with `len`=2, `pat_a`=0 -> second run accepted in the cycle after DONE. No `start` acts during `busy`. Each run reports `z_count`=1, `z_first`=1.
6. `rst` asserted in RUN step 2 of a `len`=8 run ->
   - IDLE and reset values on the next cycle.
   - `det_rst`=1 while `rst` is high.
   - No `done` pulse.
   - A following run with `len`=4, `pat_a`=0 still gives `z_count`=3.
